// File: rtl/alu_wb_buffer.sv
// In-order result buffer between the integer ALU and the scoreboard writeback port.
// Optional ALU_WB_STALL_CNT_EN adds a saturating 32-bit writeback-stall counter (stall_cnt_o).
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            wb_result_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef ALU_WB_STALL_CNT_EN
  ,output logic [31:0]               stall_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]          result_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] trans_id_mem [DEPTH];
  logic                     branch_mem [DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic                     push;
  logic                     pop;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // alu_ready_o comes from registered occupancy only, so a full buffer refuses a push
  // even in a cycle where the head is popped.
  assign alu_ready_o = (count != CW'(DEPTH));
  assign wb_valid_o  = (count != '0);
  assign push        = alu_valid_i & alu_ready_o;
  assign pop         = wb_valid_o & wb_ready_i;
  assign count_o     = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i]   <= '0;
        trans_id_mem[i] <= '0;
        branch_mem[i]   <= 1'b0;
      end
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        result_mem[wr_ptr]   <= alu_result_i;
        trans_id_mem[wr_ptr] <= alu_trans_id_i;
        branch_mem[wr_ptr]   <= alu_branch_res_i;
        wr_ptr               <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Empty buffer drives zeros rather than stale entry contents.
  always_comb begin
    wb_result_o     = '0;
    wb_trans_id_o   = '0;
    wb_branch_res_o = 1'b0;
    if (wb_valid_o) begin
      wb_result_o     = result_mem[rd_ptr];
      wb_trans_id_o   = trans_id_mem[rd_ptr];
      wb_branch_res_o = branch_mem[rd_ptr];
    end
  end

`ifdef ALU_WB_STALL_CNT_EN
  // Survives flush on purpose: it measures writeback back-pressure over the whole run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (wb_valid_o && !wb_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: driver pushes expected entries, monitor pops on writeback.
module tb_alu_wb_buffer;

  localparam int W = 68;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [63:0] alu_result_i;
  logic [2:0]  alu_trans_id_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic        wb_branch_res_o;
  logic [1:0]  count_o;
`ifdef ALU_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  int model_stall = 0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_out = '0;

  alu_wb_buffer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .alu_result_i     (alu_result_i),
    .alu_trans_id_i   (alu_trans_id_i),
    .alu_branch_res_i (alu_branch_res_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .wb_branch_res_o  (wb_branch_res_o),
    .count_o          (count_o)
`ifdef ALU_WB_STALL_CNT_EN
    ,.stall_cnt_o     (stall_cnt_o)
`endif
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT hands over an entry
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (wb_valid_o && hold_prev)
        chk("hold_stable", {wb_trans_id_o, wb_branch_res_o, wb_result_o}, prev_out);
      if (!wb_valid_o)
        chk("empty_zero", {wb_trans_id_o, wb_branch_res_o, wb_result_o}, '0);
      if (wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb: act=id%0d exp=none", wb_trans_id_o);
        end else begin
          chk("wb_data", {wb_trans_id_o, wb_branch_res_o, wb_result_o}, exp_q.pop_front());
        end
      end
      hold_prev = wb_valid_o && !wb_ready_i;
      prev_out  = {wb_trans_id_o, wb_branch_res_o, wb_result_o};
    end
  end

  // driver: one clock cycle of stimulus, with the bench's own occupancy model
  task automatic step(input logic v, input logic [63:0] res, input logic [2:0] id,
                      input logic br, input logic rdy, input logic fl);
    logic push;
    logic pop;
    logic stall;
    alu_valid_i      = v;
    alu_result_i     = res;
    alu_trans_id_i   = id;
    alu_branch_res_i = br;
    wb_ready_i       = rdy;
    flush_i          = fl;
    @(negedge clk_i);
    chk("count", count_o, model_cnt);
    chk("alu_ready", alu_ready_o, model_cnt != 2);
    chk("wb_valid", wb_valid_o, model_cnt != 0);
`ifdef ALU_WB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, model_stall);
`endif
    push  = v && (model_cnt != 2) && !fl;
    pop   = (model_cnt != 0) && rdy;
    stall = (model_cnt != 0) && !rdy;
    @(posedge clk_i);
    #1;
    if (fl) begin
      model_cnt = 0;
      exp_q.delete();
    end else begin
      if (push) exp_q.push_back({id, br, res});
      model_cnt = model_cnt + int'(push) - int'(pop);
    end
    if (stall) model_stall++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'h0, 3'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    alu_valid_i = 1'b0;
    alu_result_i = '0;
    alu_trans_id_i = '0;
    alu_branch_res_i = 1'b0;
    wb_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_alu_ready", alu_ready_o, 1);
    rst_ni = 1'b1;

    // single pass-through
    step(1'b1, 64'hDEAD_BEEF_0000_0001, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // fill under stall, refused third push, in-order drain
    step(1'b1, 64'h0000_0000_0000_0011, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0000_0022, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0000_0055, 3'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // full with simultaneous pop: push refused, count drops to 1
    step(1'b1, 64'hA5A5_0000_0000_0001, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hA5A5_0000_0000_0002, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hA5A5_0000_0000_0006, 3'd6, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // streaming wrap, no bubbles
    for (int i = 0; i < 8; i++)
      step(1'b1, 64'h1234_5678_0000_0000 | 64'(i * 3 + 1), 3'(i), i[0], 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // flush while full, with a push of ID 4 dropped
    step(1'b1, 64'h0000_0000_0000_00F1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0000_00F2, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0000_00F4, 3'd4, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush with a pop accepted in the same cycle, then refill from pointer 0
    step(1'b1, 64'h0000_0000_0000_0C01, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h0000_0000_0000_0C02, 3'd7, 1'b0, 1'b1, 1'b1);
    step(1'b1, 64'h0000_0000_0000_0C03, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // long stall, then asynchronous reset between clock edges
    step(1'b1, 64'hFFFF_0000_FFFF_0000, 3'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
`ifdef ALU_WB_STALL_CNT_EN
    chk("stall_10", stall_cnt_o, 10);
`endif
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_wb_valid", wb_valid_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_alu_ready", alu_ready_o, 1);
    chk("arst_wb_data", {wb_trans_id_o, wb_branch_res_o, wb_result_o}, '0);
`ifdef ALU_WB_STALL_CNT_EN
    chk("arst_stall_cnt", stall_cnt_o, 0);
`endif
    model_cnt = 0;
    model_stall = 0;
    exp_q.delete();
    #1;
    rst_ni = 1'b1;
    idle(1'b1);
    step(1'b1, 64'h0BAD_F00D_0000_0007, 3'd7, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    chk("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Result buffer directly downstream of the integer ALU.
- Captures each ALU result with its transaction ID and branch-compare bit, and holds it in a small in-order FIFO.
- Presents entries to the scoreboard writeback port with a valid/ready handshake, so a stalled writeback arbiter never drops an ALU result.
- Decouples the single-cycle ALU from writeback-port contention.

Parameters:
- XLEN, 64, datapath width of the result.
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.
- DEPTH, 2, number of buffer entries; must be a power of two and at least 2.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- flush_i  input  1  pipeline flush; discards all buffered entries
- alu_valid_i  input  1  ALU result valid this cycle
- alu_ready_o  output  1  buffer can accept a result this cycle
- alu_result_i  input  XLEN  ALU result
- alu_trans_id_i  input  TRANS_ID_BITS  transaction ID of the result
- alu_branch_res_i  input  1  branch comparison outcome
- wb_valid_o  output  1  head entry valid for writeback
- wb_ready_i  input  1  writeback port accepts the head entry
- wb_result_o  output  XLEN  head entry result
- wb_trans_id_o  output  TRANS_ID_BITS  head entry transaction ID
- wb_branch_res_o  output  1  head entry branch outcome
- count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: rd_ptr, wr_ptr and count are 0; all entries are cleared; wb_valid_o = 0; alu_ready_o = 1 (when rst_ni = 1); count_o = 0.
- Push: alu_valid_i & alu_ready_o. The entry is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop: wb_valid_o & wb_ready_i. rd_ptr advances modulo DEPTH.
- Occupancy: count' = count + push - pop. Simultaneous push and pop leaves count unchanged and updates both pointers.
- alu_ready_o = (count != DEPTH).
  - Depends only on registered state; there is no combinational path from wb_ready_i.
  - When full, a push is refused even if a pop occurs in the same cycle.
- wb_valid_o = (count != 0). The outputs are driven from the entry at rd_ptr.
- When empty, wb_result_o, wb_trans_id_o and wb_branch_res_o are driven to 0.
- Latency: no bypass. A result pushed in cycle N is first visible on wb_* in cycle N+1.
- Throughput: one result per cycle sustained while wb_ready_i stays high.
- Stability: while wb_valid_o & ~wb_ready_i, all wb_* outputs hold their values until the pop.
- Ordering: strictly in order; the buffer never reorders or duplicates entries.
- Flush, with priority over push and pop:
  - Next cycle, count = 0 and rd_ptr = wr_ptr = 0.
  - A push presented in the flush cycle is dropped.
  - A pop accepted in the flush cycle counts as consumed by the writeback side; the buffer takes no further action for it.
- Pointer wrap: both pointers use $clog2(DEPTH) bits, so wrap is natural overflow.
- Reset mid-operation: all state clears immediately (asynchronously); in-flight entries are lost.
- Protocol violation: alu_valid_i while alu_ready_o = 0 is ignored; the upstream stall logic must hold the instruction.

Optional Feature:
- Macro: ALU_WB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o, 32 bits.
  - Increments on every cycle with wb_valid_o & ~wb_ready_i.
  - Saturates at 0xFFFF_FFFF.
  - Resets to 0 on rst_ni; flush_i does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single pass-through: push result 0xDEAD_BEEF_0000_0001, trans_id 3, branch 1 with wb_ready_i = 1 -> next cycle wb_valid_o = 1 with the same three values; count_o returns to 0 one cycle after that.
- Fill under stall: wb_ready_i = 0, push IDs 1 then 2 -> count_o = 2 and alu_ready_o = 0; a third push with ID 5 is not accepted; raising wb_ready_i then drains ID 1, then ID 2, in order.
- Full plus simultaneous pop: count = 2, alu_valid_i = 1, wb_ready_i = 1 -> pop occurs, push refused, count_o = 1 next cycle.
- Streaming wrap: 8 back-to-back pushes with IDs 0..7 and wb_ready_i = 1 -> outputs IDs 0..7 each one cycle later, with no bubbles; pointers wrap 4 times with DEPTH = 2.
- Flush: count = 2 and flush_i = 1 together with a push of ID 4 -> next cycle count_o = 0 and wb_valid_o = 0; ID 4 is never output.
- Async reset mid-stall with ALU_WB_STALL_CNT_EN defined: 10 stall cycles give stall_cnt_o = 10; pulse rst_ni low between clock edges -> all outputs are at reset values immediately, and stall_cnt_o = 0.
